// File: rtl/conv_kernel_sched_if.sv
// Handshake bundle tying conv_kernel_sched to the window generator, the shared MAC
// and the output buffer. The scheduler uses the slave view; a driver or bench uses master.
interface conv_kernel_sched_if #(
  parameter int NUM_KERNELS = 4,
  parameter int ACC_W       = 32,
  parameter int OUT_ADDR_W  = 17
);
  localparam int KSEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

  logic                    iStart;
  logic                    iWinValid;
  logic                    oBusy;
  logic                    oMacStart;
  logic [KSEL_W-1:0]       oKernelSel;
  logic                    iMacDone;
  logic signed [ACC_W-1:0] iMacResult;
  logic                    oWrEn;
  logic [OUT_ADDR_W-1:0]   oWrAddr;
  logic [7:0]              oWrData;
  logic                    oFrameDone;
  logic                    oError;

  modport slave (
    input  iStart, iWinValid, iMacDone, iMacResult,
    output oBusy, oMacStart, oKernelSel, oWrEn, oWrAddr, oWrData, oFrameDone, oError
  );

  modport master (
    output iStart, iWinValid, iMacDone, iMacResult,
    input  oBusy, oMacStart, oKernelSel, oWrEn, oWrAddr, oWrData, oFrameDone, oError
  );
endinterface

// File: rtl/conv_kernel_sched.sv
// Time-multiplexes one MAC across NUM_KERNELS filters per 3x3 window and writes ReLU-clamped
// bytes in kernel-interleaved order. Define MAC_TIMEOUT_EN to add the WAIT_MAC watchdog/oError.
module conv_kernel_sched #(
  parameter int NUM_KERNELS = 4,
  parameter int NUM_WIN     = 478,
  parameter int ACC_W       = 32,
  parameter int OUT_ADDR_W  = 17,
  parameter int TIMEOUT     = 255
) (
  input logic               iClk,
  input logic               iRst,
  conv_kernel_sched_if.slave bus
);
  localparam int KSEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int WIN_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam logic [KSEL_W-1:0] K_LAST   = KSEL_W'(NUM_KERNELS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(NUM_WIN - 1);

  if (NUM_KERNELS < 1 || NUM_WIN < 1 || TIMEOUT < 1 || ACC_W < 9 ||
      (longint'(NUM_WIN) * NUM_KERNELS) > (longint'(1) << OUT_ADDR_W)) begin : g_bad_params
    $error("conv_kernel_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, WAIT_WIN, ISSUE, WAIT_MAC, WRITE, NEXT, DONE} state_t;

  state_t                state, state_nxt;
  logic [KSEL_W-1:0]     kernel;
  logic [WIN_W-1:0]      win;
  logic [OUT_ADDR_W-1:0] addr;
  logic [7:0]            data;
  logic                  mac_start;
  logic                  wr_en;
  logic                  frame_done;
  logic                  timeout;

  function automatic logic [7:0] relu_clamp(input logic signed [ACC_W-1:0] v);
    if (v < 0)
      return 8'd0;
    if (v > 255)
      return 8'hFF;
    return v[7:0];
  endfunction

`ifdef MAC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            error;

  // The count restarts on every WAIT_MAC entry; a done on the limit cycle still wins.
  assign timeout = (state == WAIT_MAC) && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      to_cnt <= '0;
      error  <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT_MAC) ? to_cnt + 1'b1 : '0;
      if (state == IDLE && bus.iStart)
        error <= 1'b0;
      else if (timeout && !bus.iMacDone)
        error <= 1'b1;
    end
  end

  assign bus.oError = error;
`else
  assign timeout    = 1'b0;
  assign bus.oError = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.iStart) state_nxt = WAIT_WIN;
      WAIT_WIN: if (bus.iWinValid) state_nxt = ISSUE;
      ISSUE:    state_nxt = WAIT_MAC;
      WAIT_MAC: begin
        if (bus.iMacDone)
          state_nxt = WRITE;
        else if (timeout)
          state_nxt = IDLE;
      end
      WRITE:    state_nxt = (kernel == K_LAST) ? NEXT : ISSUE;
      NEXT:     state_nxt = (win == WIN_LAST) ? DONE : WAIT_WIN;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      kernel     <= '0;
      win        <= '0;
      addr       <= '0;
      data       <= '0;
      mac_start  <= 1'b0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mac_start  <= (state_nxt == ISSUE);
      wr_en      <= (state == WAIT_MAC) && bus.iMacDone;
      frame_done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            kernel <= '0;
            win    <= '0;
            addr   <= '0;
          end
        end
        WAIT_WIN: if (bus.iWinValid) kernel <= '0;
        WAIT_MAC: if (bus.iMacDone) data <= relu_clamp(bus.iMacResult);
        WRITE: begin
          addr <= addr + 1'b1;
          if (kernel != K_LAST)
            kernel <= kernel + 1'b1;
        end
        NEXT:    win <= win + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.oBusy      = (state != WAIT_WIN);
  assign bus.oMacStart  = mac_start;
  assign bus.oKernelSel = kernel;
  assign bus.oWrEn      = wr_en;
  assign bus.oWrAddr    = addr;
  assign bus.oWrData    = data;
  assign bus.oFrameDone = frame_done;
endmodule

// File: tb/tb_conv_kernel_sched.sv
// Directed bench for conv_kernel_sched (NUM_KERNELS=2, NUM_WIN=3) with a latency-1 MAC model.
module tb_conv_kernel_sched;
  localparam int NK  = 2;
  localparam int NW  = 3;
  localparam int AW  = 32;
  localparam int OAW = 17;
  localparam int TO  = 16;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  always #5 iClk = ~iClk;

  conv_kernel_sched_if #(.NUM_KERNELS(NK), .ACC_W(AW), .OUT_ADDR_W(OAW)) bus ();

  conv_kernel_sched #(
    .NUM_KERNELS(NK), .NUM_WIN(NW), .ACC_W(AW), .OUT_ADDR_W(OAW), .TIMEOUT(TO)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  typedef struct {
    logic signed [31:0] res;
    int                 addr;
    int                 data;
  } vec_t;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  // Three frames of MAC results and the bytes they must clamp to.
  int rv[18] = '{10, 20, 30, 40, 50, 60,
                 -5, 255, 256, 32'h7FFFFFFF, 0, 128,
                 7, 300, -1, 100, 254, 1};
  int dv[18] = '{10, 20, 30, 40, 50, 60,
                 0, 255, 255, 255, 0, 128,
                 7, 255, 0, 100, 254, 1};
  vec_t tbl[18];

  int nvec  = 0;
  int nfail = 0;

  // Passive monitor
  wr_t wlog[$];
  int  klog[$];
  int  fd_cnt = 0;
  int  ms_cnt = 0;
  int  cyc    = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (bus.oWrEn) wlog.push_back('{int'(bus.oWrAddr), int'(bus.oWrData), cyc});
    if (bus.oMacStart) begin
      klog.push_back(int'(bus.oKernelSel));
      ms_cnt++;
    end
    if (bus.oFrameDone) fd_cnt++;
  end

  // MAC model: done one cycle after the start pulse, results taken in order.
  logic signed [AW-1:0] mac_res[64];
  int   mac_cnt   = 0;
  logic mac_en    = 1'b1;
  logic mac_done  = 1'b0;
  logic spur_done = 1'b0;
  logic pend      = 1'b0;

  assign bus.iMacDone = mac_done | spur_done;

  initial begin
    bus.iMacResult = '0;
    forever begin
      @(posedge iClk);
      #1;
      mac_done = pend;
      if (pend) begin
        bus.iMacResult = mac_res[mac_cnt];
        mac_cnt++;
      end
      pend = bus.oMacStart && mac_en && iRst;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load(input int f);
    for (int i = 0; i < 6; i++) mac_res[mac_cnt + i] = tbl[6*f + i].res;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    tick();
    bus.iStart = 1'b0;
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.oBusy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("win_ready", ok, 1);
  endtask

  task automatic wait_fd(input int fb);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (fd_cnt != fb) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done_seen", ok, 1);
    repeat (3) tick();
  endtask

  task automatic check_frame(input int f, input int wb, input int kb, input int fb, input bit timing);
    check("n_writes", wlog.size() - wb, 6);
    check("n_mac_starts", klog.size() - kb, 6);
    check("n_frame_done", fd_cnt - fb, 1);
    for (int i = 0; i < 6; i++) begin
      if (wb + i < wlog.size()) begin
        check($sformatf("f%0d_addr%0d", f, i), wlog[wb+i].addr, tbl[6*f + i].addr);
        check($sformatf("f%0d_data%0d", f, i), wlog[wb+i].data, tbl[6*f + i].data);
      end
      if (kb + i < klog.size())
        check($sformatf("f%0d_ksel%0d", f, i), klog[kb+i], i % NK);
    end
    if (timing && wlog.size() >= wb + 6) begin
      check("win_period_0_1", wlog[wb+2].cyc - wlog[wb].cyc, 8);
      check("win_period_1_2", wlog[wb+4].cyc - wlog[wb+2].cyc, 8);
    end
  endtask

  // Frame with the window generator always ready.
  task automatic run_frame(input int f);
    int wb, kb, fb;
    load(f);
    wb = wlog.size();
    kb = klog.size();
    fb = fd_cnt;
    pulse_start();
    bus.iWinValid = 1'b1;
    wait_fd(fb);
    bus.iWinValid = 1'b0;
    check("idle_busy_after_frame", bus.oBusy, 1);
    check_frame(f, wb, kb, fb, 1'b1);
  endtask

  initial begin
    int wb, kb, fb, ms0, bad;
    bus.iStart    = 1'b0;
    bus.iWinValid = 1'b0;
    for (int i = 0; i < 18; i++) tbl[i] = '{rv[i], i % 6, dv[i]};

    // Reset values
    #12;
    check("rst_busy", bus.oBusy, 1);
    check("rst_macstart", bus.oMacStart, 0);
    check("rst_wren", bus.oWrEn, 0);
    check("rst_framedone", bus.oFrameDone, 0);
    check("rst_error", bus.oError, 0);
    check("rst_wraddr", bus.oWrAddr, 0);
    check("rst_wrdata", bus.oWrData, 0);
    check("rst_ksel", bus.oKernelSel, 0);
    iRst = 1'b1;
    tick();

    // Basic frame and clamp frame
    run_frame(0);
    run_frame(1);

    // Stall gap with spurious iMacDone/iStart, then iStart during ISSUE
    load(2);
    wb = wlog.size();
    kb = klog.size();
    fb = fd_cnt;
    pulse_start();
    for (int w = 0; w < NW; w++) begin
      wait_ready();
      if (w == 1) begin
        bad = 0;
        ms0 = ms_cnt;
        for (int c = 0; c < 20; c++) begin
          spur_done  = (c == 5);
          bus.iStart = (c == 10);
          tick();
          if (bus.oBusy !== 1'b0) bad++;
        end
        spur_done  = 1'b0;
        bus.iStart = 1'b0;
        check("stall_busy_low", bad, 0);
        check("stall_no_macstart", ms_cnt - ms0, 0);
      end
      bus.iWinValid = 1'b1;
      tick();
      bus.iWinValid = 1'b0;
      if (w == 2) pulse_start();
    end
    wait_fd(fb);
    check_frame(2, wb, kb, fb, 1'b0);

    // Reset during WAIT_MAC of window 1
    load(0);
    wb = wlog.size();
    pulse_start();
    wait_ready();
    bus.iWinValid = 1'b1;
    tick();
    bus.iWinValid = 1'b0;
    wait_ready();
    mac_en = 1'b0;
    bus.iWinValid = 1'b1;
    tick();
    bus.iWinValid = 1'b0;
    tick();
    #3 iRst = 1'b0;
    #1;
    check("mid_rst_busy", bus.oBusy, 1);
    check("mid_rst_macstart", bus.oMacStart, 0);
    check("mid_rst_wren", bus.oWrEn, 0);
    check("mid_rst_wraddr", bus.oWrAddr, 0);
    check("mid_rst_wrdata", bus.oWrData, 0);
    check("mid_rst_ksel", bus.oKernelSel, 0);
    check("mid_rst_framedone", bus.oFrameDone, 0);
    #2 iRst = 1'b1;
    mac_en = 1'b1;
    tick();
    check("mid_rst_no_partial_write", wlog.size() - wb, 2);
    run_frame(0);

`ifdef MAC_TIMEOUT_EN
    // Watchdog: MAC never answers
    mac_en = 1'b0;
    wb = wlog.size();
    fb = fd_cnt;
    pulse_start();
    wait_ready();
    bus.iWinValid = 1'b1;
    tick();
    bus.iWinValid = 1'b0;
    tick();
    repeat (15) tick();
    check("to_error_before_limit", bus.oError, 0);
    tick();
    check("to_error_set", bus.oError, 1);
    bus.iWinValid = 1'b1;
    repeat (3) tick();
    bus.iWinValid = 1'b0;
    check("to_idle_busy", bus.oBusy, 1);
    check("to_error_sticky", bus.oError, 1);
    check("to_no_write", wlog.size() - wb, 0);
    check("to_no_framedone", fd_cnt - fb, 0);
    pulse_start();
    check("to_error_cleared", bus.oError, 0);
    iRst = 1'b0;
    #2 iRst = 1'b1;
    mac_en = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
